// File: rtl/level_pkg.sv
// Shared tile codes, game state encoding and helpers
// for the per-level coin/win/lose bookkeeping.
package level_pkg;

    localparam logic [7:0] TILE_BDR = 8'd0;
    localparam logic [7:0] TILE_SKY = 8'd1;
    localparam logic [7:0] TILE_BLK = 8'd2;
    localparam logic [7:0] TILE_GND = 8'd3;
    localparam logic [7:0] TILE_TKN = 8'd4;
    localparam logic [7:0] TILE_CK1 = 8'd5;
    localparam logic [7:0] TILE_CK2 = 8'd6;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } game_state_t;

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/coin_level_tracker_if.sv
// Background tile write port: one tile per
// valid/ready transfer.
interface coin_level_tracker_if #(
    parameter int X_W = 5,
    parameter int Y_W = 4
);
    logic           valid;
    logic           ready;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [7:0]     code;

    modport master (
        output valid, x, y, code,
        input  ready
    );

    modport slave (
        input  valid, x, y, code,
        output ready
    );
endinterface

// File: rtl/lowest_set_picker.sv
// Combinational lowest-set-bit index with
// an any-set flag.
module lowest_set_picker #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

    assign any = |req;

endmodule

// File: rtl/coin_level_tracker.sv
// Coin placement, collection, score and sticky
// win/lose for a level with NUM_COINS coins.
module coin_level_tracker
    import level_pkg::*;
#(
    parameter int          NUM_COINS   = 2,
    parameter int          X_W         = 5,
    parameter int          Y_W         = 4,
    parameter logic [7:0]  SKY         = TILE_SKY,
    parameter logic [7:0]  TKN         = TILE_TKN,
    parameter int          COIN_POINTS = 100,
    parameter int          SCORE_W     = 16,
    localparam int         CNT_W       = $clog2(NUM_COINS + 1)
) (
    input  logic                     vga_clock,
    input  logic                     reset,
    input  logic [NUM_COINS*X_W-1:0] coin_x,
    input  logic [NUM_COINS*Y_W-1:0] coin_y,
    input  logic [NUM_COINS-1:0]     touch,
    input  logic                     lose_in,
    coin_level_tracker_if.master     tile_wr,
    output logic [NUM_COINS-1:0]     collected,
    output logic [CNT_W-1:0]         coins_remaining,
    output logic [SCORE_W-1:0]       score,
    output logic                     win,
    output logic                     lose
);

    localparam int IW  = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
    localparam int SW2 = SCORE_W + 32;

    localparam logic [1:0] ST_INIT = INIT;
    localparam logic [1:0] ST_PLAY = PLAY;
    localparam logic [1:0] ST_WIN  = WIN;
    localparam logic [1:0] ST_LOSE = LOSE;

    logic [1:0]           state;
    logic [IW-1:0]        init_idx;
    logic [IW-1:0]        sel;
    logic [IW-1:0]        pick;
    logic                 any;
    logic                 lose_req;
    logic [NUM_COINS-1:0] pending;
    logic [NUM_COINS-1:0] new_mask;
    logic [NUM_COINS-1:0] done_mask;
    logic [NUM_COINS-1:0] cand;
    logic [CNT_W-1:0]     gain_cnt;
    logic [CNT_W-1:0]     rem_nx;
    logic [SW2-1:0]       sum;
    logic                 wr_valid;
    logic [X_W-1:0]       wr_x;
    logic [Y_W-1:0]       wr_y;
    logic [7:0]           wr_code;
    logic                 accept;

    function automatic logic [X_W-1:0] col(input logic [IW-1:0] i);
        return coin_x[int'(i)*X_W +: X_W];
    endfunction

    function automatic logic [Y_W-1:0] row(input logic [IW-1:0] i);
        return coin_y[int'(i)*Y_W +: Y_W];
    endfunction

    assign accept        = wr_valid & tile_wr.ready;
    assign tile_wr.valid = wr_valid;
    assign tile_wr.x     = wr_x;
    assign tile_wr.y     = wr_y;
    assign tile_wr.code  = wr_code;

    // The in-flight coin keeps its pending bit until accepted.
    always_comb begin
        new_mask  = '0;
        done_mask = '0;
        if (state == ST_PLAY) new_mask = touch & ~collected;
        if (accept && state != ST_INIT) done_mask[sel] = 1'b1;
        cand     = (pending & ~done_mask) | new_mask;
        gain_cnt = CNT_W'(popcount(16'(new_mask)));
        rem_nx   = coins_remaining - gain_cnt;
        sum      = SW2'(score)
                 + SW2'(gain_cnt) * SW2'(COIN_POINTS);
    end

    lowest_set_picker #(.N(NUM_COINS)) u_pick (
        .req (cand),
        .idx (pick),
        .any (any)
    );

    always_ff @(posedge vga_clock) begin
        if (!reset) begin
            state           <= ST_INIT;
            init_idx        <= '0;
            sel             <= '0;
            lose_req        <= 1'b0;
            collected       <= '0;
            pending         <= '0;
            coins_remaining <= CNT_W'(NUM_COINS);
            score           <= '0;
            win             <= 1'b0;
            lose            <= 1'b0;
            wr_valid        <= 1'b0;
            wr_x            <= '0;
            wr_y            <= '0;
            wr_code         <= '0;
        end else begin
            unique case (state)
                ST_INIT: begin
                    if (lose_in) lose_req <= 1'b1;
                    if (!wr_valid) begin
                        wr_valid <= 1'b1;
                        wr_x     <= col(init_idx);
                        wr_y     <= row(init_idx);
                        wr_code  <= TKN;
                    end else if (accept) begin
                        if (init_idx == IW'(NUM_COINS - 1)) begin
                            wr_valid <= 1'b0;
                            if (lose_req || lose_in) begin
                                state <= ST_LOSE;
                                lose  <= 1'b1;
                            end else begin
                                state <= ST_PLAY;
                            end
                        end else begin
                            init_idx <= init_idx + 1'b1;
                            wr_x     <= col(init_idx + 1'b1);
                            wr_y     <= row(init_idx + 1'b1);
                        end
                    end
                end
                default: begin
                    collected <= collected | new_mask;
                    pending   <= cand;
                    if (state == ST_PLAY) begin
                        coins_remaining <= rem_nx;
                        score <= (sum > SW2'({SCORE_W{1'b1}}))
                               ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
                        if (lose_in) begin
                            state <= ST_LOSE;
                            lose  <= 1'b1;
                        end else if (rem_nx == '0) begin
                            state <= ST_WIN;
                            win   <= 1'b1;
                        end
                    end
                    if (!wr_valid || accept) begin
                        wr_valid <= any;
                        if (any) begin
                            sel     <= pick;
                            wr_x    <= col(pick);
                            wr_y    <= row(pick);
                            wr_code <= SKY;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_level_tracker.sv
// Directed-vector bench for coin_level_tracker with
// two- and four-coin instances.
module tb_coin_level_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // two-coin instance
    logic        rst2;
    logic [9:0]  coin_x2;
    logic [7:0]  coin_y2;
    logic [1:0]  touch2;
    logic        lose_in2;
    logic [1:0]  col2;
    logic [1:0]  rem2;
    logic [15:0] score2;
    logic        win2;
    logic        lose2;

    coin_level_tracker_if #(.X_W(5), .Y_W(4)) if2 ();

    coin_level_tracker #(.NUM_COINS(2)) dut2 (
        .vga_clock       (clk),
        .reset           (rst2),
        .coin_x          (coin_x2),
        .coin_y          (coin_y2),
        .touch           (touch2),
        .lose_in         (lose_in2),
        .tile_wr         (if2.master),
        .collected       (col2),
        .coins_remaining (rem2),
        .score           (score2),
        .win             (win2),
        .lose            (lose2)
    );

    // four-coin instance
    logic        rst4;
    logic [19:0] coin_x4;
    logic [15:0] coin_y4;
    logic [3:0]  touch4;
    logic        lose_in4;
    logic [3:0]  col4;
    logic [2:0]  rem4;
    logic [15:0] score4;
    logic        win4;
    logic        lose4;

    coin_level_tracker_if #(.X_W(5), .Y_W(4)) if4 ();

    coin_level_tracker #(.NUM_COINS(4)) dut4 (
        .vga_clock       (clk),
        .reset           (rst4),
        .coin_x          (coin_x4),
        .coin_y          (coin_y4),
        .touch           (touch4),
        .lose_in         (lose_in4),
        .tile_wr         (if4.master),
        .collected       (col4),
        .coins_remaining (rem4),
        .score           (score4),
        .win             (win4),
        .lose            (lose4)
    );

    initial begin
        rst2 = 1'b0; touch2 = '0; lose_in2 = 1'b0;
        coin_x2 = {5'd14, 5'd6};
        coin_y2 = {4'd2, 4'd6};
        if2.ready = 1'b1;
        rst4 = 1'b0; touch4 = '0; lose_in4 = 1'b0;
        coin_x4 = {5'd11, 5'd8, 5'd5, 5'd2};
        coin_y4 = {4'd7, 4'd5, 4'd3, 4'd1};
        if4.ready = 1'b1;
        tick(); tick();

        check("rst_valid", if2.valid, 0);
        check("rst_rem", rem2, 2);
        check("rst_score", score2, 0);
        check("rst_win", win2, 0);
        check("rst_lose", lose2, 0);
        check("rst_col", col2, 0);
        check("rst_rem4", rem4, 4);

        // init walk
        rst2 = 1'b1;
        tick();
        check("init0_valid", if2.valid, 1);
        check("init0_x", if2.x, 6);
        check("init0_y", if2.y, 6);
        check("init0_code", if2.code, 4);
        tick();
        check("init1_x", if2.x, 14);
        check("init1_y", if2.y, 2);
        check("init1_code", if2.code, 4);
        touch2 = 2'b11;
        tick();
        touch2 = 2'b00;
        check("play_valid", if2.valid, 0);
        check("init_touch_col", col2, 0);
        check("init_touch_rem", rem2, 2);

        // single collection
        touch2 = 2'b01;
        tick();
        touch2 = 2'b00;
        check("c0_col", col2, 1);
        check("c0_rem", rem2, 1);
        check("c0_score", score2, 100);
        check("c0_valid", if2.valid, 1);
        check("c0_x", if2.x, 6);
        check("c0_y", if2.y, 6);
        check("c0_code", if2.code, 1);
        check("c0_win", win2, 0);
        tick();
        check("c0_done", if2.valid, 0);

        // double touch then win
        touch2 = 2'b01;
        tick();
        check("dbl_rem", rem2, 1);
        check("dbl_score", score2, 100);
        touch2 = 2'b10;
        tick();
        touch2 = 2'b00;
        check("win_win", win2, 1);
        check("win_rem", rem2, 0);
        check("win_score", score2, 200);
        check("win_col", col2, 3);
        check("win_x", if2.x, 14);
        check("win_code", if2.code, 1);
        lose_in2 = 1'b1;
        touch2 = 2'b01;
        tick();
        lose_in2 = 1'b0;
        touch2 = 2'b00;
        check("win_nolose", lose2, 0);
        check("win_hold", win2, 1);
        check("win_frozen", score2, 200);

        // lose priority on last coin
        rst2 = 1'b0;
        tick();
        rst2 = 1'b1;
        tick(); tick(); tick();
        touch2 = 2'b01;
        tick();
        touch2 = 2'b10;
        lose_in2 = 1'b1;
        tick();
        touch2 = 2'b00;
        lose_in2 = 1'b0;
        check("lp_lose", lose2, 1);
        check("lp_win", win2, 0);
        check("lp_rem", rem2, 0);
        check("lp_score", score2, 200);
        check("lp_valid", if2.valid, 1);
        check("lp_x", if2.x, 14);
        check("lp_code", if2.code, 1);

        // reset mid-handshake
        rst2 = 1'b0;
        tick();
        rst2 = 1'b1;
        tick(); tick(); tick();
        if2.ready = 1'b0;
        touch2 = 2'b01;
        tick();
        touch2 = 2'b00;
        tick();
        check("mid_valid", if2.valid, 1);
        check("mid_x", if2.x, 6);
        check("mid_code", if2.code, 1);
        rst2 = 1'b0;
        tick();
        check("mr_valid", if2.valid, 0);
        check("mr_score", score2, 0);
        check("mr_rem", rem2, 2);
        rst2 = 1'b1;
        if2.ready = 1'b1;
        tick();
        check("mr_init_x", if2.x, 6);
        check("mr_init_code", if2.code, 4);
        tick();
        check("mr_init1_x", if2.x, 14);

        // four coins, simultaneous touches
        rst4 = 1'b1;
        tick();
        check("w4_0", if4.x, 2);
        tick();
        check("w4_1", if4.x, 5);
        tick();
        check("w4_2", if4.x, 8);
        tick();
        check("w4_3x", if4.x, 11);
        check("w4_3y", if4.y, 7);
        tick();
        check("w4_play", if4.valid, 0);
        if4.ready = 1'b0;
        touch4 = 4'b0101;
        tick();
        touch4 = 4'b0000;
        check("s4_rem", rem4, 2);
        check("s4_score", score4, 200);
        check("s4_col", col4, 5);
        check("s4_valid", if4.valid, 1);
        check("s4_x", if4.x, 2);
        check("s4_y", if4.y, 1);
        repeat (4) tick();
        check("s4_hold_v", if4.valid, 1);
        check("s4_hold_x", if4.x, 2);
        check("s4_hold_c", if4.code, 1);
        if4.ready = 1'b1;
        tick();
        check("s4_c2_valid", if4.valid, 1);
        check("s4_c2_x", if4.x, 8);
        check("s4_c2_y", if4.y, 5);
        tick();
        check("s4_idle", if4.valid, 0);
        check("s4_nowin", win4, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
